// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter: grants one requester at a time the write port of a
// downstream FIFO and holds the grant until end-of-packet or L words, whichever
// comes first. One idle bubble separates consecutive grants.
module fifo_wr_arbiter #(
    parameter int unsigned B = 8,
    parameter int unsigned N = 4,
    parameter int unsigned L = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         req_valid,
    input  logic [N*B-1:0]       req_data,
    input  logic [N-1:0]         req_last,
    output logic [N-1:0]         req_ready,
    input  logic                 fifo_full,
    output logic                 fifo_w,
    output logic [B-1:0]         fifo_w_data,
    output logic [$clog2(N)-1:0] grant_id,
    output logic                 busy
);

    localparam int unsigned IW = $clog2(N);
    localparam int unsigned CW = $clog2(L + 1);

    typedef enum logic {StIdle, StLock} state_e;

    state_e        r_state, w_state_next;
    logic [IW-1:0] r_grant_id, w_grant_id_next;
    logic [IW-1:0] r_rr_ptr, w_rr_ptr_next;
    logic [CW-1:0] r_cnt, w_cnt_next;

    logic [IW-1:0] w_pick;
    logic [IW-1:0] w_idx;
    logic          w_any;
    logic          w_xfer;
    logic          w_release;

    // Round-robin search: first valid requester at or after rr_ptr (N is a power
    // of two, so the IW-bit add wraps modulo N for free).
    always_comb begin
        w_pick = '0;
        w_any  = 1'b0;
        w_idx  = r_rr_ptr;
        for (int unsigned k = 0; k < N; k++) begin
            w_idx = r_rr_ptr + IW'(k);
            if (!w_any && req_valid[w_idx]) begin
                w_pick = w_idx;
                w_any  = 1'b1;
            end
        end
    end

    // A transfer needs the grant holder's valid and room in the FIFO.
    assign w_xfer    = (r_state == StLock) && req_valid[r_grant_id] && !fifo_full;
    assign w_release = w_xfer && (req_last[r_grant_id] || (r_cnt == CW'(L - 1)));

    // Steer the grant holder's word straight through to the FIFO.
    always_comb begin
        fifo_w_data = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (r_grant_id == IW'(i)) begin
                fifo_w_data = req_data[i*B +: B];
            end
        end
    end

    // Next-state logic and handshake outputs.
    always_comb begin
        w_state_next    = r_state;
        w_grant_id_next = r_grant_id;
        w_rr_ptr_next   = r_rr_ptr;
        w_cnt_next      = r_cnt;
        req_ready       = '0;
        fifo_w          = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (w_any) begin
                    w_state_next    = StLock;
                    w_grant_id_next = w_pick;
                    w_cnt_next      = '0;
                end
            end
            StLock: begin
                req_ready[r_grant_id] = !fifo_full;
                fifo_w                = w_xfer;
                if (w_xfer) begin
                    w_cnt_next = r_cnt + CW'(1);
                end
                if (w_release) begin
                    w_state_next  = StIdle;
                    w_rr_ptr_next = r_grant_id + IW'(1);
                end
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    // State registers with asynchronous active-high reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= StIdle;
            r_grant_id <= '0;
            r_rr_ptr   <= '0;
            r_cnt      <= '0;
        end else begin
            r_state    <= w_state_next;
            r_grant_id <= w_grant_id_next;
            r_rr_ptr   <= w_rr_ptr_next;
            r_cnt      <= w_cnt_next;
        end
    end

    assign grant_id = r_grant_id;
    assign busy     = (r_state == StLock);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: directed packets per requester, expected
// FIFO writes pushed in hand-computed arbitration order, monitor pops on fifo_w.
module tb_fifo_wr_arbiter;

    localparam int B = 8;
    localparam int N = 4;
    localparam int L = 16;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   req_valid = '0;
    logic [N*B-1:0] req_data = '0;
    logic [N-1:0]   req_last = '0;
    logic [N-1:0]   req_ready;
    logic           fifo_full = 1'b0;
    logic           fifo_w;
    logic [B-1:0]   fifo_w_data;
    logic [1:0]     grant_id;
    logic           busy;

    fifo_wr_arbiter #(.B(B), .N(N), .L(L)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_last    (req_last),
        .req_ready   (req_ready),
        .fifo_full   (fifo_full),
        .fifo_w      (fifo_w),
        .fifo_w_data (fifo_w_data),
        .grant_id    (grant_id),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         id;
        logic [7:0] data;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   wr_cyc[$];
    int   gap_exp[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   n_writes = 0;

    logic [B-1:0] src_data [N][64];
    logic         src_last [N][64];
    int           src_len  [N];
    int           src_pos  [N];
    logic [N-1:0] drv_fire;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got 0x%0h required 0x%0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Requester model: present head word of each queue, pop on handshake.
    always begin
        @(negedge clk);
        drv_fire = req_valid & req_ready;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (drv_fire[i]) src_pos[i]++;
            if (src_pos[i] < src_len[i]) begin
                req_valid[i]       = 1'b1;
                req_data[i*B +: B] = src_data[i][src_pos[i]];
                req_last[i]        = src_last[i][src_pos[i]];
            end else begin
                req_valid[i]       = 1'b0;
                req_data[i*B +: B] = '0;
                req_last[i]        = 1'b0;
            end
        end
    end

    // Monitor: every FIFO write must match the next expected word.
    always @(negedge clk) begin
        if (!rst) begin
            if (fifo_full) chk("no_write_when_full", 32'(fifo_w), 32'(0));
            if (fifo_w === 1'b1) begin
                n_writes++;
                wr_cyc.push_back(cyc);
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_write: got data 0x%0h grant %0d required no write",
                             fifo_w_data, grant_id);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("wr_data", 32'(fifo_w_data), 32'(mon_e.data));
                    chk("wr_grant", 32'(grant_id), 32'(mon_e.id));
                    chk("wr_ready", 32'(req_ready), 32'(1) << mon_e.id);
                end
            end
        end
    end

    task automatic load(input int r, input logic [7:0] first, input int n, input logic last_end);
        for (int k = 0; k < n; k++) begin
            src_data[r][src_len[r]] = first + 8'(k);
            src_last[r][src_len[r]] = last_end && (k == n - 1);
            src_len[r]++;
        end
    endtask

    task automatic exp_pkt(input int id, input logic [7:0] first, input int n);
        for (int k = 0; k < n; k++) exp_q.push_back('{id: id, data: first + 8'(k)});
    endtask

    task automatic clear_test();
        wr_cyc.delete();
        gap_exp.delete();
        n_writes = 0;
    endtask

    task automatic clear_src();
        for (int i = 0; i < N; i++) begin
            src_len[i] = 0;
            src_pos[i] = 0;
        end
        exp_q.delete();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_src();
        clear_test();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_fifo_w", 32'(fifo_w), 32'(0));
        chk("rst_ready", 32'(req_ready), 32'(0));
        chk("rst_grant", 32'(grant_id), 32'(0));
        rst = 1'b0;
    endtask

    task automatic wait_drain(input string name, input int budget, input logic need_idle);
        int n = 0;
        while ((exp_q.size() != 0 || (need_idle && busy !== 1'b0)) && n < budget) begin
            @(posedge clk);
            #2;
            n++;
        end
        chk({name, "_drained"}, 32'(exp_q.size()), 32'(0));
        if (need_idle) chk({name, "_idle"}, 32'(busy), 32'(0));
        exp_q.delete();
    endtask

    task automatic check_gaps(input string name);
        chk({name, "_nwrites"}, 32'(wr_cyc.size()), 32'(gap_exp.size() + 1));
        for (int i = 0; i < gap_exp.size() && i + 1 < wr_cyc.size(); i++) begin
            chk({name, "_gap"}, 32'(wr_cyc[i+1] - wr_cyc[i]), 32'(gap_exp[i]));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // Two 3-word packets on requesters 0 and 2.
        do_reset();
        load(0, 8'h00, 3, 1'b1);
        load(2, 8'h80, 3, 1'b1);
        exp_pkt(0, 8'h00, 3);
        exp_pkt(2, 8'h80, 3);
        gap_exp = '{1, 1, 2, 1, 1};
        wait_drain("t1", 60, 1'b1);
        check_gaps("t1");

        // rr_ptr is now 3: requester 3 wins over requester 0.
        clear_test();
        load(0, 8'h10, 1, 1'b1);
        load(3, 8'hC0, 1, 1'b1);
        exp_pkt(3, 8'hC0, 1);
        exp_pkt(0, 8'h10, 1);
        gap_exp = '{2};
        wait_drain("t1b", 40, 1'b1);
        check_gaps("t1b");

        // All four continuously valid with single-word packets.
        do_reset();
        for (int i = 0; i < N; i++) begin
            load(i, 8'(64 * i), 1, 1'b1);
            load(i, 8'(64 * i + 1), 1, 1'b1);
        end
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < N; i++) exp_pkt(i, 8'(64 * i + r), 1);
        end
        gap_exp = '{2, 2, 2, 2, 2, 2, 2};
        wait_drain("t2", 80, 1'b1);
        check_gaps("t2");

        // 20-word stream without last: forced release after 16, requester 2 next.
        do_reset();
        load(1, 8'h40, 20, 1'b0);
        load(2, 8'h80, 1, 1'b1);
        exp_pkt(1, 8'h40, 16);
        exp_pkt(2, 8'h80, 1);
        exp_pkt(1, 8'h50, 4);
        for (int i = 0; i < 15; i++) gap_exp.push_back(1);
        gap_exp.push_back(2);
        gap_exp.push_back(2);
        for (int i = 0; i < 3; i++) gap_exp.push_back(1);
        wait_drain("t3", 120, 1'b0);
        check_gaps("t3");
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("t3_hold_busy", 32'(busy), 32'(1));
        chk("t3_hold_grant", 32'(grant_id), 32'(1));

        // FIFO full for 5 cycles mid-packet.
        do_reset();
        load(0, 8'h20, 6, 1'b1);
        exp_pkt(0, 8'h20, 6);
        begin
            int n = 0;
            while (n_writes < 2 && n < 40) begin
                @(posedge clk);
                #2;
                n++;
            end
        end
        chk("t4_two_written", 32'(n_writes), 32'(2));
        fifo_full = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("t4_full_fifo_w", 32'(fifo_w), 32'(0));
            chk("t4_full_ready", 32'(req_ready), 32'(0));
            chk("t4_full_busy", 32'(busy), 32'(1));
        end
        @(posedge clk);
        #2;
        fifo_full = 1'b0;
        wait_drain("t4", 60, 1'b1);
        chk("t4_total_writes", 32'(n_writes), 32'(6));

        // Reset in the middle of requester 3's packet after 7 words.
        do_reset();
        load(3, 8'hE0, 10, 1'b1);
        exp_pkt(3, 8'hE0, 7);
        wait_drain("t5_pre", 60, 1'b0);
        #1;
        rst = 1'b1;
        #1;
        chk("t5_rst_busy", 32'(busy), 32'(0));
        chk("t5_rst_fifo_w", 32'(fifo_w), 32'(0));
        chk("t5_rst_ready", 32'(req_ready), 32'(0));
        chk("t5_rst_grant", 32'(grant_id), 32'(0));
        clear_src();
        clear_test();
        load(1, 8'h44, 1, 1'b1);
        load(3, 8'hF0, 1, 1'b1);
        exp_pkt(1, 8'h44, 1);
        exp_pkt(3, 8'hF0, 1);
        gap_exp = '{2};
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        wait_drain("t5", 40, 1'b1);
        check_gaps("t5");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
